serial_rx_framed: RTL

Parametrised asynchronous-serial receiver with 16x oversampling, a runtime baud divisor, configurable parity and stop bits, and majority-vote bit sampling. It sits between a raw `rx` pin and any byte consumer. Each received word is delivered on a valid/ready handshake with per-word error flags. Break and overrun conditions are reported separately.

---
 rtl/serial_pkg.sv | 27 ++
 rtl/baud_tick_gen.sv | 34 +++
 rtl/serial_rx_framed.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/serial_pkg.sv
// Shared definitions for the asynchronous-serial receive/transmit blocks.
package serial_pkg;

    localparam int PAR_NONE = 0;
    localparam int PAR_EVEN = 1;
    localparam int PAR_ODD  = 2;

    localparam int         OS_TICKS  = 16;
    localparam logic [3:0] SMP_FIRST = 4'd7;
    localparam logic [3:0] SMP_MID   = 4'd8;
    localparam logic [3:0] SMP_LAST  = 4'd9;
    localparam logic [3:0] SC_LAST   = 4'(OS_TICKS - 1);

    typedef enum logic [2:0] {
        RX_INIT,
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_PARITY,
        RX_STOP
    } rx_state_t;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/baud_tick_gen.sv
// Oversample tick generator: one tick every (div_q+1) clocks, divisor latched only while load is high.
module baud_tick_gen #(
    parameter int DIV_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DIV_WIDTH-1:0] div,
    input  logic                 load,
    output logic                 tick
);

    logic [DIV_WIDTH-1:0] div_q;
    logic [DIV_WIDTH-1:0] cnt;

    // >= keeps the counter from running the full range if div shrinks mid-count
    assign tick = (cnt >= div_q);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_q <= '0;
            cnt   <= '0;
        end else begin
            if (load) begin
                div_q <= div;
            end
            if (tick) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/serial_rx_framed.sv
// 16x-oversampled serial receiver with majority-vote sampling, parity/stop checks,
// break detection and a valid/ready word output with overrun reporting.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// RX_INIT   | wait for the line to be seen idle (high) before listening
// RX_IDLE   | line idle, divisor tracks input, look for a start edge
// RX_START  | validate start bit at mid-bit, reject glitches
// RX_DATA   | shift in WIDTH data bits, LSB first
// RX_PARITY | capture the parity bit
// RX_STOP   | check stop bit(s); last one completes the frame at mid-bit
module serial_rx_framed
    import serial_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int DIV_WIDTH = 16,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx,
    input  logic [DIV_WIDTH-1:0] div,
    output logic [WIDTH-1:0]     data,
    output logic                 valid,
    input  logic                 ready,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 overrun,
    output logic                 break_det
);

    rx_state_t state, state_nx;

    logic             rx_m, rx_s;
    logic             tick, div_load;
    logic [3:0]       sc;
    logic             smp7, smp8;
    logic [4:0]       bc;
    logic [WIDTH-1:0] shreg;
    logic             par_bit, stop_err, stop_idx;

    logic bit_val, at_mid, at_wrap, last_bit, last_stop;
    logic stop_bad, par_exp, par_bad, is_break_frame;
    logic deliver, brk_hit;

    baud_tick_gen #(.DIV_WIDTH(DIV_WIDTH)) u_tick (
        .clk  (clk),
        .rst  (rst),
        .div  (div),
        .load (div_load),
        .tick (tick)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_m <= 1'b1;
            rx_s <= 1'b1;
        end else begin
            rx_m <= rx;
            rx_s <= rx_m;
        end
    end

    assign bit_val   = maj3(smp7, smp8, rx_s);
    assign at_mid    = tick && (sc == SMP_LAST);
    assign at_wrap   = tick && (sc == SC_LAST);
    assign last_bit  = (bc == 5'(WIDTH - 1));
    assign last_stop = (STOP_BITS == 1) || stop_idx;
    assign stop_bad  = stop_err || !bit_val;
    assign par_exp   = (^shreg) ^ (PARITY == PAR_ODD);
    assign par_bad   = (PARITY != PAR_NONE) && (par_bit != par_exp);
    // A break looks like an all-zero frame whose stop bit is also low
    assign is_break_frame = (shreg == '0) && ((PARITY == PAR_NONE) || !par_bit) && stop_bad;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= RX_INIT;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            RX_INIT: begin
                if (rx_s) state_nx = RX_IDLE;
            end
            RX_IDLE: begin
                if (tick && !rx_s) state_nx = RX_START;
            end
            RX_START: begin
                if (at_mid && bit_val) state_nx = RX_IDLE;
                else if (at_wrap)      state_nx = RX_DATA;
            end
            RX_DATA: begin
                if (at_wrap && last_bit) begin
                    state_nx = (PARITY != PAR_NONE) ? RX_PARITY : RX_STOP;
                end
            end
            RX_PARITY: begin
                if (at_wrap) state_nx = RX_STOP;
            end
            RX_STOP: begin
                if (at_mid && last_stop) begin
                    state_nx = (is_break_frame || stop_bad) ? RX_INIT : RX_IDLE;
                end
            end
            default: state_nx = RX_INIT;
        endcase
    end

    always_comb begin
        div_load = 1'b0;
        deliver  = 1'b0;
        brk_hit  = 1'b0;
        case (state)
            RX_INIT, RX_IDLE: div_load = 1'b1;
            RX_STOP: begin
                if (at_mid && last_stop) begin
                    brk_hit = is_break_frame;
                    deliver = !is_break_frame;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sc       <= '0;
            smp7     <= 1'b0;
            smp8     <= 1'b0;
            bc       <= '0;
            shreg    <= '0;
            par_bit  <= 1'b0;
            stop_err <= 1'b0;
            stop_idx <= 1'b0;
        end else if (state == RX_INIT || state == RX_IDLE) begin
            sc       <= '0;
            bc       <= '0;
            stop_err <= 1'b0;
            stop_idx <= 1'b0;
        end else begin
            if (tick) sc <= sc + 4'd1;
            if (tick && sc == SMP_FIRST) smp7 <= rx_s;
            if (tick && sc == SMP_MID)   smp8 <= rx_s;
            if (state == RX_DATA && at_mid)   shreg <= {bit_val, shreg[WIDTH-1:1]};
            if (state == RX_DATA && at_wrap)  bc <= last_bit ? 5'd0 : bc + 5'd1;
            if (state == RX_PARITY && at_mid) par_bit <= bit_val;
            if (state == RX_STOP && at_mid)   stop_err <= stop_bad;
            if (state == RX_STOP && at_wrap)  stop_idx <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data       <= '0;
            valid      <= 1'b0;
            frame_err  <= 1'b0;
            parity_err <= 1'b0;
            overrun    <= 1'b0;
            break_det  <= 1'b0;
        end else begin
            overrun   <= deliver && valid && !ready;
            break_det <= brk_hit;
            if (deliver && (!valid || ready)) begin
                data       <= shreg;
                frame_err  <= stop_bad;
                parity_err <= par_bad;
                valid      <= 1'b1;
            end else if (valid && ready) begin
                valid <= 1'b0;
            end
        end
    end

endmodule
